spi_slave_regfile: RTL

// - SPI target (responder) for the 3-wire/4-wire SPI master on the same bus; models a peripheral register file.
// - Decodes 16-bit command (R/W + address) then 8-bit data bytes; auto-increments address per byte.
// - Fully synchronous to Sys_Clock: bus pins are oversampled; no logic clocked by SPI_CLK.
// - Local side gives system logic a registered read port and a write port into the same register file.

---
 rtl/spi_hw_pkg.sv | 15 +
 rtl/spi_slave_regfile_if.sv | 29 ++
 rtl/spi_sync_edge.sv | 25 ++
 rtl/spi_slave_regfile.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_hw_pkg.sv
// Shared constants and FSM state encoding for the SPI register-file target.
package spi_hw_pkg;

  localparam int SPI_CMD_LEN  = 16;
  localparam int SPI_DATA_LEN = 8;
  localparam int RW_BIT       = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WR   = 2'd2,
    ST_RD   = 2'd3
  } state_t;

endpackage

// File: rtl/spi_slave_regfile_if.sv
// SPI bus bundle between the master and the register-file target.
// Bus protocol: a frame is SPI_SYNC low. The master moves SPI_CLK and
// drives SPI_MOSI MSB first. The target drives SPI_MISO only while
// SPI_MISO_OE is high, which happens during the read data phase only.
// There is no valid/ready flow control: each sample edge of SPI_CLK
// transfers exactly one bit in each direction.
interface spi_slave_regfile_if;
  logic SPI_CLK;
  logic SPI_SYNC;
  logic SPI_MOSI;
  logic SPI_MISO;
  logic SPI_MISO_OE;

  modport master (
    output SPI_CLK,
    output SPI_SYNC,
    output SPI_MOSI,
    input  SPI_MISO,
    input  SPI_MISO_OE
  );

  modport slave (
    input  SPI_CLK,
    input  SPI_SYNC,
    input  SPI_MOSI,
    output SPI_MISO,
    output SPI_MISO_OE
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous bus pin plus one history
// flop, giving single-cycle rise/fall pulses in the system clock domain.
module spi_sync_edge #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [2:0] s;

  // Shift the pin through two sync stages and one history stage; the reset
  // value matches the pin's idle level so release creates no false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s <= {3{RESET_VAL}};
    else        s <= {s[1:0], d};
  end

  assign rise =  s[1] & ~s[2];
  assign fall = ~s[1] &  s[2];

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI target modelling a small register file. Everything runs on
// Sys_Clock; the bus pins are oversampled and edge-detected. A local
// read/write port gives system logic access to the same registers.
module spi_slave_regfile
  import spi_hw_pkg::*;
#(
  parameter int SPI_Clock_Pority = 1,
  parameter int SPI_Edge         = 1,
  parameter int SPI_Command_Len  = SPI_CMD_LEN,
  parameter int SPI_Data_Len     = SPI_DATA_LEN,
  parameter int SPI_Read_Pority  = 1,
  parameter int REG_DEPTH        = 16,
  localparam int ADDR_W          = $clog2(REG_DEPTH)
) (
  input  logic                    Sys_Clock,
  input  logic                    nReset,
  spi_slave_regfile_if.slave      spi,
  input  logic [ADDR_W-1:0]       Loc_Rd_Addr,
  output logic [SPI_Data_Len-1:0] Loc_Rd_Data,
  input  logic                    Loc_Wr,
  input  logic [ADDR_W-1:0]       Loc_Wr_Addr,
  input  logic [SPI_Data_Len-1:0] Loc_Wr_Data,
  output logic                    Loc_Wr_Drop,
  output logic                    Wr_Strobe,
  output logic [ADDR_W-1:0]       Wr_Addr,
  output logic [SPI_Data_Len-1:0] Wr_Data,
  output logic                    Frame_Error,
  output logic                    Busy,
  output state_t                  Dbg_State
);

  localparam int CNT_W = $clog2(SPI_Command_Len);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(SPI_Command_Len - 1);
  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(SPI_Data_Len - 1);
  localparam bit READ_VAL = (SPI_Read_Pority != 0);

  logic [1:0] rst_pipe;
  logic       rst_n;
  logic [1:0] mosi_s;
  logic       mosi;
  logic       clk_rise, clk_fall, sync_rise, sync_fall;
  logic       sample_edge, launch_edge, in_frame, spi_wr;

  state_t                    state;
  logic [CNT_W-1:0]          bit_cnt;
  logic [SPI_Command_Len-2:0] shift_in;
  logic [SPI_Data_Len-2:0]   shift_out;
  logic [ADDR_W-1:0]         addr;
  logic [ADDR_W-1:0]         addr_inc;
  logic [ADDR_W-1:0]         cmd_addr;
  logic [SPI_Data_Len-1:0]   byte_next;
  logic                      miso, oe;
  logic [SPI_Data_Len-1:0]   regs [REG_DEPTH];

  // Reset asserts immediately but releases synchronously to Sys_Clock.
  always_ff @(posedge Sys_Clock or negedge nReset) begin
    if (!nReset) rst_pipe <= 2'b00;
    else         rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  spi_sync_edge #(.RESET_VAL(SPI_Clock_Pority != 0)) u_clk_sync (
    .clk  (Sys_Clock),
    .rst_n(rst_n),
    .d    (spi.SPI_CLK),
    .rise (clk_rise),
    .fall (clk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_sync (
    .clk  (Sys_Clock),
    .rst_n(rst_n),
    .d    (spi.SPI_SYNC),
    .rise (sync_rise),
    .fall (sync_fall)
  );

  // MOSI only needs synchronising; its two stages keep it aligned with the
  // detected clock edge.
  always_ff @(posedge Sys_Clock or negedge rst_n) begin
    if (!rst_n) mosi_s <= 2'b00;
    else        mosi_s <= {mosi_s[0], spi.SPI_MOSI};
  end
  assign mosi = mosi_s[1];

  // Edge roles, next-address helpers and the SPI write-this-cycle flag.
  always_comb begin
    sample_edge = (SPI_Edge != 0) ? clk_rise : clk_fall;
    launch_edge = (SPI_Edge != 0) ? clk_fall : clk_rise;
    addr_inc    = addr + 1'b1;
    cmd_addr    = {shift_in[ADDR_W-2:0], mosi};
    byte_next   = {shift_in[SPI_Data_Len-2:0], mosi};
    in_frame    = (state != ST_IDLE) && !sync_rise && !sync_fall;
    spi_wr      = in_frame && (state == ST_WR) && sample_edge && (bit_cnt == BYTE_LAST);
  end

  // Frame FSM, shifters, address counter, register array and local port.
  always_ff @(posedge Sys_Clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shift_in    <= '0;
      shift_out   <= '0;
      addr        <= '0;
      miso        <= 1'b0;
      oe          <= 1'b0;
      Wr_Strobe   <= 1'b0;
      Wr_Addr     <= '0;
      Wr_Data     <= '0;
      Frame_Error <= 1'b0;
      Loc_Wr_Drop <= 1'b0;
      Loc_Rd_Data <= '0;
      for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
    end else begin
      Wr_Strobe   <= 1'b0;
      Frame_Error <= 1'b0;
      Loc_Wr_Drop <= 1'b0;
      Loc_Rd_Data <= regs[Loc_Rd_Addr];

      if (sync_rise) begin
        // A non-zero bit count means the frame ended inside a command or byte.
        if (state != ST_IDLE && bit_cnt != '0) Frame_Error <= 1'b1;
        state   <= ST_IDLE;
        bit_cnt <= '0;
        miso    <= 1'b0;
        oe      <= 1'b0;
      end else if (sync_fall) begin
        state   <= ST_CMD;
        bit_cnt <= '0;
        miso    <= 1'b0;
        oe      <= 1'b0;
      end else begin
        case (state)
          ST_CMD: begin
            if (sample_edge) begin
              shift_in <= {shift_in[SPI_Command_Len-3:0], mosi};
              if (bit_cnt == CMD_LAST) begin
                bit_cnt <= '0;
                addr    <= cmd_addr;
                if (shift_in[RW_BIT-1] == READ_VAL) begin
                  // First read byte goes out before the next sample edge.
                  state     <= ST_RD;
                  shift_out <= regs[cmd_addr][SPI_Data_Len-2:0];
                  miso      <= regs[cmd_addr][SPI_Data_Len-1];
                  oe        <= 1'b1;
                end else begin
                  state <= ST_WR;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          ST_WR: begin
            if (sample_edge) begin
              shift_in <= {shift_in[SPI_Command_Len-3:0], mosi};
              if (bit_cnt == BYTE_LAST) begin
                regs[addr] <= byte_next;
                Wr_Strobe  <= 1'b1;
                Wr_Addr    <= addr;
                Wr_Data    <= byte_next;
                addr       <= addr_inc;
                bit_cnt    <= '0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          ST_RD: begin
            if (sample_edge) begin
              if (bit_cnt == BYTE_LAST) begin
                addr      <= addr_inc;
                shift_out <= regs[addr_inc][SPI_Data_Len-2:0];
                miso      <= regs[addr_inc][SPI_Data_Len-1];
                bit_cnt   <= '0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else if (launch_edge && bit_cnt != '0) begin
              // The launch edge right after a (re)load is skipped: bit 7 is
              // already on the wire.
              miso      <= shift_out[SPI_Data_Len-2];
              shift_out <= {shift_out[SPI_Data_Len-3:0], 1'b0};
            end
          end
          default: ;
        endcase
      end

      // The SPI write owns the array in its cycle; a local write then is lost.
      if (Loc_Wr) begin
        if (spi_wr) Loc_Wr_Drop <= 1'b1;
        else        regs[Loc_Wr_Addr] <= Loc_Wr_Data;
      end
    end
  end

  assign spi.SPI_MISO    = miso;
  assign spi.SPI_MISO_OE = oe;
  assign Busy            = (state != ST_IDLE);
  assign Dbg_State       = state;

endmodule
